seq_and_n: RTL and testbench

- Parametrised multi-channel sequence-AND checker for the assertion RTL library.
- An attempt is launched by `en`.
- The attempt matches once every enabled channel has been seen high at least once within a bounded window.
- It fails if the window expires with any enabled channel still unseen.
- Generalises the two-signal AND operator: N channels, per-attempt channel mask, timeout window, single-cycle verdict pulses and saturating verdict counters.

---
 rtl/seq_pkg.sv | 23 ++
 rtl/seq_and_n_if.sv | 29 ++
 rtl/sat_counter.sv | 29 ++
 rtl/seq_and_n.sv | 123 ++++++++++++
 tb/tb_seq_and_n.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/seq_pkg.sv
// Shared types and helpers for the sequence-operator checker family.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package seq_pkg;

  // Attempt state for the sequence checkers.
  typedef enum logic {
    IDLE = 1'b0,
    EVAL = 1'b1
  } seq_state_e;

  // Width of a delay counter that must hold values 0..max_dly.
  function automatic int dly_w(input int max_dly);
    return $clog2(max_dly + 1);
  endfunction

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/seq_and_n_if.sv
// Bundle of attempt-control inputs and verdict outputs for seq_and_n.
// Latency: n/a (wiring only).
// Backpressure: none; launches are dropped while an attempt is in progress.
// Ports: master drives en/sig/mask/clr_cnt and observes status; slave is the checker.
interface seq_and_n_if #(
  parameter int N_SIG = 2,
  parameter int CNT_W = 16
);
  logic             en;
  logic [N_SIG-1:0] sig;
  logic [N_SIG-1:0] mask;
  logic             clr_cnt;
  logic             busy;
  logic [N_SIG-1:0] seen;
  logic             match;
  logic             fail;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] fail_cnt;

  modport master (
    output en, sig, mask, clr_cnt,
    input  busy, seen, match, fail, match_cnt, fail_cnt
  );

  modport slave (
    input  en, sig, mask, clr_cnt,
    output busy, seen, match, fail, match_cnt, fail_cnt
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating event counter with synchronous clear.
// Latency: count updates on the edge where inc is sampled high.
// Backpressure: none; clr wins over a same-edge inc, count sticks at all-ones.
// Ports: clk, rst_n, inc (count event), clr (force zero), cnt (current count).
module sat_counter
  import seq_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  localparam logic [31:0] MAX_VAL = 32'((64'd1 << CNT_W) - 64'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= CNT_W'(sat_inc(32'(cnt), MAX_VAL));
    end
  end

endmodule

// File: rtl/seq_and_n.sv
// Multi-channel sequence-AND checker: every masked channel must be seen high within a window.
// Latency: match/fail pulse one cycle after the deciding edge; window is edges t..t+MAX_DLY.
// Backpressure: en is ignored while busy and on the deciding edge; no queueing.
// Ports: clk, rst_n, bus (slave modport: en/sig/mask/clr_cnt in, busy/seen/match/fail/counters out).
module seq_and_n
  import seq_pkg::*;
#(
  parameter int N_SIG   = 2,
  parameter int MAX_DLY = 8,
  parameter int CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  seq_and_n_if.slave  bus
);

  localparam int            DW   = dly_w(MAX_DLY);
  localparam logic [DW-1:0] LAST = DW'(MAX_DLY);

  seq_state_e       state;
  logic [N_SIG-1:0] mask_q;
  logic [N_SIG-1:0] seen_q;
  logic [DW-1:0]    dly_q;
  logic             busy_q;
  logic             match_q;
  logic             fail_q;

  logic [N_SIG-1:0] hit;
  logic [N_SIG-1:0] seen_nxt;
  logic [DW-1:0]    dly_nxt;
  logic             launch;
  logic             match_set;
  logic             fail_set;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] fail_cnt;

  // Decision logic for the current edge. Masked-off channels are gated
  // before anything else so X on them never reaches state.
  always_comb begin
    hit       = '0;
    seen_nxt  = seen_q;
    dly_nxt   = dly_q;
    launch    = 1'b0;
    match_set = 1'b0;
    fail_set  = 1'b0;
    if (state == IDLE) begin
      hit       = bus.sig & bus.mask;
      seen_nxt  = hit;
      dly_nxt   = '0;
      launch    = bus.en;
      // All requested channels already high at launch (or empty mask).
      match_set = bus.en && (hit == bus.mask);
    end else begin
      hit       = bus.sig & mask_q;
      seen_nxt  = seen_q | hit;
      dly_nxt   = dly_q + DW'(1);
      match_set = (seen_nxt == mask_q);
      // Completion on the last window edge counts as a match.
      fail_set  = !match_set && (dly_nxt == LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      mask_q  <= '0;
      seen_q  <= '0;
      dly_q   <= '0;
      busy_q  <= 1'b0;
      match_q <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      match_q <= match_set;
      fail_q  <= fail_set;
      case (state)
        IDLE: begin
          if (launch) begin
            mask_q <= bus.mask;
            seen_q <= seen_nxt;
            dly_q  <= '0;
            if (!match_set) begin
              state  <= EVAL;
              busy_q <= 1'b1;
            end
          end
        end
        EVAL: begin
          seen_q <= seen_nxt;
          dly_q  <= dly_nxt;
          if (match_set || fail_set) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_match_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (match_set),
    .clr   (bus.clr_cnt),
    .cnt   (match_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_fail_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (fail_set),
    .clr   (bus.clr_cnt),
    .cnt   (fail_cnt)
  );

  assign bus.busy      = busy_q;
  assign bus.seen      = seen_q;
  assign bus.match     = match_q;
  assign bus.fail      = fail_q;
  assign bus.match_cnt = match_cnt;
  assign bus.fail_cnt  = fail_cnt;

endmodule

// File: tb/tb_seq_and_n.sv
// Bench for seq_and_n: directed scenarios plus random traffic against a window-scan model.
// Latency: outputs sampled 1ns after each rising edge.
// Backpressure: n/a.
module tb_seq_and_n;

  localparam int MAXD = 8;
  localparam int DEPTH = 512;

  logic clk;
  logic rst_n;

  seq_and_n_if #(.N_SIG(2), .CNT_W(16)) bus1 ();
  seq_and_n_if #(.N_SIG(2), .CNT_W(2))  bus2 ();

  seq_and_n #(.N_SIG(2), .MAX_DLY(MAXD), .CNT_W(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1.slave));
  seq_and_n #(.N_SIG(2), .MAX_DLY(MAXD), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stimulus per edge index, and expected register values after that edge.
  logic       en_a   [DEPTH];
  logic [1:0] sig_a  [DEPTH];
  logic [1:0] mask_a [DEPTH];
  logic       clr_a  [DEPTH];
  logic       exp_busy  [DEPTH];
  logic [1:0] exp_seen  [DEPTH];
  logic       exp_match [DEPTH];
  logic       exp_fail  [DEPTH];
  int         exp_mc  [DEPTH];
  int         exp_fc  [DEPTH];
  int         exp_mc2 [DEPTH];
  int         exp_fc2 [DEPTH];

  // Model state carried between runs.
  logic [1:0] m_seen = 2'b00;
  int m_mc = 0, m_fc = 0, m_mc2 = 0, m_fc2 = 0;

  task automatic chk(input string tag, input int step, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s step %0d observed %0h expected %0h", tag, step, obs, expv);
    end
  endtask

  task automatic drive(input logic e, input logic [1:0] s, input logic [1:0] m, input logic c);
    bus1.en = e; bus1.sig = s; bus1.mask = m; bus1.clr_cnt = c;
    bus2.en = e; bus2.sig = s; bus2.mask = m; bus2.clr_cnt = c;
  endtask

  task automatic clear_stim();
    for (int i = 0; i < DEPTH; i++) begin
      en_a[i] = 1'b0; sig_a[i] = 2'b00; mask_a[i] = 2'b00; clr_a[i] = 1'b0;
    end
  endtask

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Each accepted launch scans its window of edges for the first edge where
  // the accumulated masked channels cover the mask; otherwise it fails on the
  // last window edge. Launches before the previous verdict edge has passed are dropped.
  task automatic build_expected(input int n);
    int         free_at;
    int         d;
    int         vd [DEPTH];
    logic       seen_set [DEPTH];
    logic [1:0] seen_val [DEPTH];
    logic [1:0] acc;
    logic [1:0] m;
    logic [1:0] sv;
    free_at = 0;
    for (int i = 0; i < DEPTH; i++) begin
      vd[i] = 0; seen_set[i] = 1'b0; seen_val[i] = 2'b00; exp_busy[i] = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      if (i >= free_at && en_a[i]) begin
        m = mask_a[i];
        acc = 2'b00;
        d = -1;
        for (int k = 0; k <= MAXD && i + k < DEPTH; k++) begin
          acc = acc | (sig_a[i+k] & m);
          seen_set[i+k] = 1'b1;
          seen_val[i+k] = acc;
          if (acc == m) begin
            d = i + k;
            break;
          end
        end
        if (d < 0) begin
          d = i + MAXD;
          vd[d] = 2;
        end else begin
          vd[d] = 1;
        end
        for (int j = i; j < d; j++) exp_busy[j] = 1'b1;
        free_at = d + 1;
      end
    end
    sv = m_seen;
    for (int k = 0; k < n; k++) begin
      if (seen_set[k]) sv = seen_val[k];
      exp_seen[k]  = sv;
      exp_match[k] = (vd[k] == 1);
      exp_fail[k]  = (vd[k] == 2);
      if (clr_a[k]) begin
        m_mc = 0; m_fc = 0; m_mc2 = 0; m_fc2 = 0;
      end else begin
        if (vd[k] == 1) begin m_mc = min_i(m_mc + 1, 65535); m_mc2 = min_i(m_mc2 + 1, 3); end
        if (vd[k] == 2) begin m_fc = min_i(m_fc + 1, 65535); m_fc2 = min_i(m_fc2 + 1, 3); end
      end
      exp_mc[k] = m_mc; exp_fc[k] = m_fc; exp_mc2[k] = m_mc2; exp_fc2[k] = m_fc2;
    end
    m_seen = sv;
  endtask

  task automatic run_seq(input int n);
    build_expected(n);
    for (int i = 0; i < n; i++) begin
      drive(en_a[i], sig_a[i], mask_a[i], clr_a[i]);
      @(posedge clk);
      #1;
      chk("busy",  i, 32'(bus1.busy),      32'(exp_busy[i]));
      chk("seen",  i, 32'(bus1.seen),      32'(exp_seen[i]));
      chk("match", i, 32'(bus1.match),     32'(exp_match[i]));
      chk("fail",  i, 32'(bus1.fail),      32'(exp_fail[i]));
      chk("mcnt",  i, 32'(bus1.match_cnt), 32'(exp_mc[i]));
      chk("fcnt",  i, 32'(bus1.fail_cnt),  32'(exp_fc[i]));
      chk("mcnt2", i, 32'(bus2.match_cnt), 32'(exp_mc2[i]));
      chk("fcnt2", i, 32'(bus2.fail_cnt),  32'(exp_fc2[i]));
    end
    drive(1'b0, 2'b00, 2'b00, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 2'b00, 2'b00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",  0, 32'(bus1.busy),      32'd0);
    chk("rst_seen",  0, 32'(bus1.seen),      32'd0);
    chk("rst_match", 0, 32'(bus1.match),     32'd0);
    chk("rst_fail",  0, 32'(bus1.fail),      32'd0);
    chk("rst_mcnt",  0, 32'(bus1.match_cnt), 32'd0);
    chk("rst_fcnt",  0, 32'(bus1.fail_cnt),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: channel 0 at t+2, channel 1 at t+5 -> match after edge t+5.
    clear_stim();
    en_a[0] = 1'b1; mask_a[0] = 2'b11;
    sig_a[2] = 2'b01; sig_a[5] = 2'b10;
    run_seq(12);
    chk("t1_seen", 0, 32'(bus1.seen),      32'd3);
    chk("t1_mcnt", 0, 32'(bus1.match_cnt), 32'd1);

    // 2: channel 1 never arrives -> fail after edge t+8.
    clear_stim();
    en_a[0] = 1'b1; mask_a[0] = 2'b11;
    sig_a[2] = 2'b01;
    run_seq(12);
    chk("t2_seen", 0, 32'(bus1.seen),     32'd1);
    chk("t2_fcnt", 0, 32'(bus1.fail_cnt), 32'd1);

    // 3: immediate match at launch; vacuous match with empty mask and X on gated channels.
    clear_stim();
    en_a[0] = 1'b1; mask_a[0] = 2'b11; sig_a[0] = 2'b11;
    en_a[2] = 1'b1; mask_a[2] = 2'b00; sig_a[2] = 2'bxx;
    run_seq(5);
    chk("t3_seen", 0, 32'(bus1.seen),      32'd0);
    chk("t3_mcnt", 0, 32'(bus1.match_cnt), 32'd3);

    // 4: last channel on the final window edge, ignored en pulses, relaunch on verdict cycle.
    clear_stim();
    en_a[0] = 1'b1; mask_a[0] = 2'b11; sig_a[0] = 2'b01;
    en_a[3] = 1'b1; mask_a[3] = 2'b11;
    en_a[8] = 1'b1; mask_a[8] = 2'b11; sig_a[8] = 2'b10;
    en_a[9] = 1'b1; mask_a[9] = 2'b11;
    sig_a[10] = 2'b11;
    run_seq(14);
    chk("t4_mcnt", 0, 32'(bus1.match_cnt), 32'd5);
    chk("t4_fcnt", 0, 32'(bus1.fail_cnt),  32'd1);

    // 5: asynchronous reset in the middle of an attempt.
    clear_stim();
    en_a[0] = 1'b1; mask_a[0] = 2'b11;
    run_seq(4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_busy",  0, 32'(bus1.busy),      32'd0);
    chk("t5_seen",  0, 32'(bus1.seen),      32'd0);
    chk("t5_mcnt",  0, 32'(bus1.match_cnt), 32'd0);
    chk("t5_fcnt",  0, 32'(bus1.fail_cnt),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    m_seen = 2'b00; m_mc = 0; m_fc = 0; m_mc2 = 0; m_fc2 = 0;
    clear_stim();
    run_seq(12);

    // 6: saturation of the narrow counters, then clear on a match edge.
    clear_stim();
    for (int i = 0; i < 5; i++) begin
      en_a[i] = 1'b1; mask_a[i] = 2'b11; sig_a[i] = 2'b11;
    end
    run_seq(5);
    chk("t6_sat",  0, 32'(bus2.match_cnt), 32'd3);
    chk("t6_wide", 0, 32'(bus1.match_cnt), 32'd5);
    clear_stim();
    en_a[0] = 1'b1; mask_a[0] = 2'b11; sig_a[0] = 2'b11; clr_a[0] = 1'b1;
    run_seq(3);
    chk("t6_clr2", 0, 32'(bus2.match_cnt), 32'd0);
    chk("t6_clr1", 0, 32'(bus1.match_cnt), 32'd0);

    // Random traffic with an idle tail so every attempt finishes.
    clear_stim();
    for (int i = 0; i < 300; i++) begin
      en_a[i]   = ($urandom_range(0, 2) == 0);
      sig_a[i]  = 2'($urandom_range(0, 3));
      mask_a[i] = 2'($urandom_range(0, 3));
      clr_a[i]  = ($urandom_range(0, 49) == 0);
      if ($urandom_range(0, 3) != 0) sig_a[i] = sig_a[i] & 2'($urandom_range(0, 3));
    end
    run_seq(312);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
